// File: rtl/arbitro_rr.sv
// arbitro_rr: 4-way round-robin bus arbiter with registered outputs; optional hold timeout via ARBITRO_RR_TIMEOUT_EN
module arbitro_rr #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_num,
  output logic       available,
  output logic       preempt
);
  typedef enum logic [1:0] {IDLE, OWN, PREEMPT} state_t;
  state_t state, state_n;
  logic [3:0] grant_n;
  logic [1:0] grant_num_n, last, last_n, win;
  logic available_n, preempt_n, keep;
`ifdef ARBITRO_RR_TIMEOUT_EN
  logic [3:0] hold_cnt, hold_n;
`endif
  if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_hold
    $error("MAX_HOLD must be 2..15");
  end
  always_comb begin
    win = last;
    for (int k = 4; k >= 1; k--) if (req[last + 2'(k)]) win = last + 2'(k);
  end
  assign keep = (state == OWN) && req[grant_num];
  always_comb begin
    state_n = state;
    grant_n = grant;
    grant_num_n = grant_num;
    last_n = last;
    available_n = 1'b0;
    preempt_n = 1'b0;
`ifdef ARBITRO_RR_TIMEOUT_EN
    hold_n = hold_cnt;
`endif
    if (!keep) begin
      if (req == 4'b0) begin
        state_n = IDLE;
        grant_n = 4'b0;
        grant_num_n = 2'd0;
        available_n = 1'b1;
      end else begin
        state_n = OWN;
        grant_n = 4'b1 << win;
        grant_num_n = win;
        last_n = win;
`ifdef ARBITRO_RR_TIMEOUT_EN
        hold_n = 4'd1;
`endif
      end
    end
`ifdef ARBITRO_RR_TIMEOUT_EN
    else if (hold_cnt == 4'(MAX_HOLD) && |(req & ~grant)) begin
      state_n = PREEMPT;
      grant_n = 4'b0;
      grant_num_n = 2'd0;
      preempt_n = 1'b1;
    end else hold_n = (hold_cnt == 4'(MAX_HOLD)) ? hold_cnt : hold_cnt + 4'd1;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0;
      grant_num <= 2'd0;
      available <= 1'b1;
      preempt <= 1'b0;
      last <= 2'd3;
`ifdef ARBITRO_RR_TIMEOUT_EN
      hold_cnt <= 4'd0;
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_num <= grant_num_n;
      available <= available_n;
      preempt <= preempt_n;
      last <= last_n;
`ifdef ARBITRO_RR_TIMEOUT_EN
      hold_cnt <= hold_n;
`endif
    end
  end
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr: directed and randomized self-checking bench for arbitro_rr
module tb_arbitro_rr;
  localparam int MH = 8;
`ifdef ARBITRO_RR_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic [1:0] grant_num;
  logic available, preempt;
  int errors = 0, checks = 0;
  int m_own = -1, m_last = 3, m_cnt = 0;
  bit m_pre = 1'b0;
  arbitro_rr #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .grant_num(grant_num), .available(available), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_own = -1; m_pre = 1'b0; m_last = 3; m_cnt = 0;
    end else if (m_own >= 0 && r[m_own]) begin
      if (TO && m_cnt == MH && (r & ~(4'b1 << m_own)) != 4'b0) begin
        m_pre = 1'b1; m_own = -1;
      end else if (m_cnt < MH) m_cnt++;
    end else begin
      m_pre = 1'b0;
      m_own = -1;
      for (int k = 1; k <= 4 && m_own < 0; k++) if (r[(m_last + k) % 4]) m_own = (m_last + k) % 4;
      if (m_own >= 0) begin m_last = m_own; m_cnt = 1; end
    end
    #1;
  endtask
  task automatic test_reset();
    step(4'b1111, 1'b1);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (grant_num !== 2'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", grant_num); end
    checks++; if (available !== 1'b1) begin errors++; $display("FAIL reset_avail got=%b exp=1", available); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
  endtask
  task automatic test_first_grant();
    step(4'b0000, 1'b1);
    step(4'b0110, 1'b0);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL first_grant got=%b exp=0010", grant); end
    checks++; if (grant_num !== 2'd1) begin errors++; $display("FAIL first_num got=%0d exp=1", grant_num); end
    checks++; if (available !== 1'b0) begin errors++; $display("FAIL first_avail got=%b exp=0", available); end
  endtask
  task automatic test_handoff();
    step(4'b0110, 1'b0);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL hold1 got=%b exp=0010", grant); end
    step(4'b0101, 1'b0);
    checks++; if (grant !== 4'b0100 || grant_num !== 2'd2) begin errors++; $display("FAIL handoff2 got=%b/%0d exp=0100/2", grant, grant_num); end
    step(4'b0001, 1'b0);
    checks++; if (grant !== 4'b0001 || grant_num !== 2'd0 || available !== 1'b0) begin errors++; $display("FAIL handoff0 got=%b/%0d/%b exp=0001/0/0", grant, grant_num, available); end
    step(4'b0000, 1'b0);
    checks++; if (grant !== 4'b0 || available !== 1'b1) begin errors++; $display("FAIL release_idle got=%b/%b exp=0000/1", grant, available); end
  endtask
  task automatic test_fairness();
    logic [3:0] e;
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b0);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rr_start got=%b exp=0001", grant); end
    for (int i = 0; i < 4; i++) begin
      e = 4'b1 << i;
      step(4'b1111, 1'b0);
      checks++; if (grant !== e) begin errors++; $display("FAIL rr_hold%0d got=%b exp=%b", i, grant, e); end
      step(4'b1111 & ~e, 1'b0);
      e = 4'b1 << ((i + 1) % 4);
      checks++; if (grant !== e) begin errors++; $display("FAIL rr_next%0d got=%b exp=%b", i, grant, e); end
    end
  endtask
  task automatic test_timeout();
    step(4'b0000, 1'b1);
    for (int i = 0; i < MH; i++) begin
      step(4'b0011, 1'b0);
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL to_hold%0d got=%b exp=0001", i, grant); end
    end
    step(4'b0011, 1'b0);
    checks++; if (grant !== (TO ? 4'b0000 : 4'b0001) || preempt !== TO || available !== 1'b0) begin
      errors++; $display("FAIL to_preempt got=%b/%b/%b exp=%b/%b/0", grant, preempt, available, TO ? 4'b0000 : 4'b0001, TO);
    end
    step(4'b0011, 1'b0);
    checks++; if (grant !== (TO ? 4'b0010 : 4'b0001) || preempt !== 1'b0) begin
      errors++; $display("FAIL to_after got=%b/%b exp=%b/0", grant, preempt, TO ? 4'b0010 : 4'b0001);
    end
    step(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 1'b0);
      checks++; if (grant !== 4'b0001 || preempt !== 1'b0) begin errors++; $display("FAIL solo%0d got=%b/%b exp=0001/0", i, grant, preempt); end
    end
  endtask
  task automatic test_reset_mid();
    step(4'b0000, 1'b1);
    step(4'b1000, 1'b0);
    checks++; if (grant !== 4'b1000 || grant_num !== 2'd3) begin errors++; $display("FAIL own3 got=%b/%0d exp=1000/3", grant, grant_num); end
    step(4'b1000, 1'b1);
    checks++; if (grant !== 4'b0 || available !== 1'b1) begin errors++; $display("FAIL mid_reset got=%b/%b exp=0000/1", grant, available); end
    step(4'b1001, 1'b0);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL post_reset got=%b exp=0001", grant); end
  endtask
  task automatic test_random();
    logic [3:0] r, eg;
    logic rs;
    r = 4'b0;
    step(4'b0000, 1'b1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rs = ($urandom_range(0, 99) == 0);
      step(r, rs);
      eg = (m_own >= 0) ? 4'b1 << m_own : 4'b0;
      checks++;
      if (grant !== eg || grant_num !== 2'((m_own >= 0) ? m_own : 0) ||
          available !== (m_own < 0 && !m_pre) || preempt !== m_pre) begin
        errors++;
        $display("FAIL rand%0d req=%b got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", i, r, grant, grant_num, available, preempt,
                 eg, (m_own >= 0) ? m_own : 0, (m_own < 0 && !m_pre), m_pre);
      end
    end
  endtask
  initial begin
    test_reset();
    test_first_grant();
    test_handoff();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner before preemption (legal 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request lines; bit i = device i requests the bus.
REQ-005 grant  output  4  registered one-hot grant; all-zero = no owner.
REQ-006 grant_num  output  2  registered binary index of current owner; 0 when no owner.
REQ-007 available  output  1  registered; 1 when arbiter is in IDLE (bus free).
REQ-008 preempt  output  1  registered; 1 for exactly the one cycle of the PREEMPT state.

Function
REQ-009 FSM states SHALL be IDLE, OWN, PREEMPT; outputs SHALL be driven from registers only (no combinational path req -> outputs).
REQ-010 Round-robin pointer last[1:0] SHALL hold the most recently granted index; priority search order SHALL be last+1, last+2, last+3, last (mod 4).
REQ-011 IDLE, req==0: stay IDLE, grant=0, grant_num=0, available=1.
REQ-012 IDLE, req!=0: next cycle -> OWN, grant=onehot(winner), grant_num=winner, last<=winner, hold_cnt<=1, available=0 (one-cycle grant latency).
REQ-013 OWN, req[owner]=1, not timed out: hold grant unchanged; hold_cnt increments, saturating at MAX_HOLD.
REQ-014 OWN, req[owner]=0 and other requests pending: next cycle grant SHALL move directly to RR winner (no dead cycle), last<=winner, hold_cnt<=1.
REQ-015 OWN, req[owner]=0 and req==0: next cycle -> IDLE, grant=0, grant_num=0, available=1.
REQ-016 OWN, req[owner]=1, hold_cnt==MAX_HOLD and (req & ~grant)!=0: next cycle -> PREEMPT, grant=0, grant_num=0, preempt=1, available=0.
REQ-017 OWN, hold_cnt==MAX_HOLD and no other request: grant held, hold_cnt saturated, no preemption.
REQ-018 PREEMPT: exactly one cycle; then arbitrate as in IDLE using current req (former owner lowest priority); req==0 -> IDLE.
REQ-019 PREEMPT where only former owner still requests: former owner re-granted, hold_cnt<=1.
REQ-020 Simultaneous release by owner and new requests on the same edge SHALL be handled per REQ-014; requests arriving in the same cycle compete only by RR order.
REQ-021 grant SHALL never have more than one bit set; grant_num SHALL always equal the index of the set bit.

Reset
REQ-022 rst=1 at a rising edge SHALL force: state=IDLE, grant=0, grant_num=0, available=1, preempt=0, hold_cnt=0, last=3 (first search order 0,1,2,3).
REQ-023 Reset asserted mid-ownership or during PREEMPT SHALL drop grant on the next edge; rst SHALL take priority over all transitions.
REQ-024 First arbitration after reset release SHALL use req sampled on the first edge with rst=0.

Configuration
REQ-025 Macro ARBITRO_RR_TIMEOUT_EN defined: hold_cnt, MAX_HOLD check and PREEMPT state SHALL be implemented per REQ-013..REQ-019.
REQ-026 Macro undefined: no hold counter; owner keeps grant while req[owner]=1 indefinitely; PREEMPT unreachable; preempt tied to 0; all other behaviour identical.

Verification
REQ-027 Reset then req=4'b0110 -> one cycle later grant=4'b0010, grant_num=1, available=0; previous cycle available=1.
REQ-028 Owner 1 holds, then req=4'b0101 (1 drops) -> next cycle grant=4'b0100, grant_num=2; then req=4'b0001 -> grant=4'b0001, grant_num=0, no idle cycle between.
REQ-029 req=4'b1111 held, owners release after 2 cycles each -> grant order 0,1,2,3,0 (RR fairness).
REQ-030 TIMEOUT_EN, MAX_HOLD=8, req=4'b0011 held constant -> grant=4'b0001 for 8 cycles, 1 cycle grant=0/preempt=1, then grant=4'b0010; without macro grant=4'b0001 forever.
REQ-031 TIMEOUT_EN, req=4'b0001 alone for 20 cycles -> grant=4'b0001 throughout, preempt never 1.
REQ-032 rst=1 during ownership of device 3 -> next edge grant=0, available=1; after release with req=4'b1001 -> grant=4'b0001.
